out_port_receiver: RTL and testbench

//  Device-side endpoint for the CPU output port: accepts 32-bit words written by the CPU

---
 rtl/port_pkg.sv | 10 +
 rtl/port_fifo_mem.sv | 23 ++
 rtl/out_port_receiver.sv | 77 +++++++
 tb/tb_out_port_receiver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/port_pkg.sv
// Shared constants and types for the CPU output-port receiver.
package port_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/port_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Storage is intentionally not reset; validity is tracked by the pointers/count.
module port_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/out_port_receiver.sv
// Device-side endpoint of the CPU output port: buffers CPU words in a small
// fall-through FIFO and hands them out over valid/ready. Full is registered so
// the control unit sees no combinational path from wr_en; drops set a sticky flag.
module out_port_receiver
  import port_pkg::*;
#(
  parameter int DATA_W = port_pkg::DATA_W,
  parameter int DEPTH  = port_pkg::DEPTH,
  parameter int ADDR_W = port_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              dev_valid,
  output logic [DATA_W-1:0] dev_data,
  input  logic              dev_ready
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;
  logic [DATA_W-1:0] head_word;

  port_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (head_word)
  );

  // Handshake decode and next-state; full comes from the registered flag so a
  // write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    push       = wr_en && !full_q;
    pop        = (count_q != '0) && dev_ready;
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
    else if (!push && pop) count_d = count_q - (ADDR_W+1)'(1);
    full_d     = (count_d == (ADDR_W+1)'(DEPTH));
    overflow_d = overflow_q;
    if (wr_en && full_q)   overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  // Control state with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign dev_valid = (count_q != '0);
  assign dev_data  = dev_valid ? head_word : '0;
endmodule

// File: tb/tb_out_port_receiver.sv
// Directed bench for out_port_receiver: hand-computed expectations, immediate assertions.
module tb_out_port_receiver;
  import port_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        overflow_clr;
  logic        dev_valid;
  logic [31:0] dev_data;
  logic        dev_ready;

  int checks   = 0;
  int failures = 0;

  out_port_receiver dut (
    .clock        (clock),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .dev_valid    (dev_valid),
    .dev_data     (dev_data),
    .dev_ready    (dev_ready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b0; wr_en = 1'b0; wr_data = '0; overflow_clr = 1'b0; dev_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(dev_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", dev_data, 0);
    clear = 1'b1;
    tick();

    // Fill with no consumer, then drain in order.
    wr_en = 1'b1; wr_data = 32'h11;
    tick();
    chk("fwft_valid", 32'(dev_valid), 1);
    chk("fwft_data", dev_data, 32'h11);
    chk("fill_cnt1", 32'(count), 1);
    wr_data = 32'h22; tick();
    wr_data = 32'h33; tick();
    chk("fill_notfull", 32'(full), 0);
    wr_data = 32'h44; tick();
    chk("fill_full", 32'(full), 1);
    chk("fill_cnt4", 32'(count), 4);
    wr_en = 1'b0; dev_ready = 1'b1;
    chk("drain0", dev_data, 32'h11);
    tick(); chk("drain1", dev_data, 32'h22);
    chk("drain_notfull", 32'(full), 0);
    tick(); chk("drain2", dev_data, 32'h33);
    tick(); chk("drain3", dev_data, 32'h44);
    tick();
    chk("drain_valid0", 32'(dev_valid), 0);
    chk("drain_data0", dev_data, 0);
    chk("drain_cnt0", 32'(count), 0);
    chk("drain_full0", 32'(full), 0);
    dev_ready = 1'b0;

    // Overflow: write while full with a simultaneous pop is dropped.
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 32'(i); tick();
    end
    chk("ovf_full", 32'(full), 1);
    wr_data = 32'hDEAD; dev_ready = 1'b1;
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_cnt3", 32'(count), 3);
    chk("ovf_head", dev_data, 32'h2);
    wr_en = 1'b0; dev_ready = 1'b0; overflow_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(overflow), 0);
    overflow_clr = 1'b0;
    wr_en = 1'b1; wr_data = 32'h5;
    tick();
    chk("ovf_refull", 32'(full), 1);
    wr_data = 32'hDEAD; overflow_clr = 1'b1;
    tick();
    chk("ovf_setwins", 32'(overflow), 1);
    chk("ovf_cnt4", 32'(count), 4);
    wr_en = 1'b0;
    tick();
    chk("ovf_clr2", 32'(overflow), 0);
    overflow_clr = 1'b0; dev_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("ovf_drain", dev_data, 32'(i));
      tick();
    end
    chk("ovf_empty", 32'(dev_valid), 0);

    // Streaming: one-cycle latency, count stays 1, pointers wrap.
    wr_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      wr_data = 32'(i);
      tick();
      chk("stream_data", dev_data, 32'(i));
      chk("stream_cnt", 32'(count), 1);
    end
    wr_en = 1'b0;
    tick();
    chk("stream_end", 32'(count), 0);
    dev_ready = 1'b0;

    // Backpressure: head stays stable while not accepted.
    wr_en = 1'b1; wr_data = 32'hA5A5A5A5; tick();
    wr_data = 32'h5A; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", dev_data, 32'hA5A5A5A5);
      chk("bp_valid", 32'(dev_valid), 1);
    end
    dev_ready = 1'b1; tick(); dev_ready = 1'b0;
    chk("bp_next", dev_data, 32'h5A);
    tick();
    chk("bp_hold2", dev_data, 32'h5A);
    dev_ready = 1'b1; tick(); dev_ready = 1'b0;
    chk("bp_empty", 32'(dev_valid), 0);

    // Empty corner: write plus ready while empty is push-only.
    wr_en = 1'b1; wr_data = 32'h7; dev_ready = 1'b1;
    tick();
    chk("empty_cnt", 32'(count), 1);
    chk("empty_data", dev_data, 32'h7);
    wr_en = 1'b0; dev_ready = 1'b0;
    tick();
    chk("empty_hold", 32'(count), 1);

    // Asynchronous reset mid-run with 3 words held and overflow set.
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h100 + 32'(i); tick();
    end
    wr_data = 32'hBEEF; dev_ready = 1'b1; tick();
    wr_en = 1'b0; dev_ready = 1'b0;
    chk("pre_rst_cnt", 32'(count), 3);
    chk("pre_rst_ovf", 32'(overflow), 1);
    #2 clear = 1'b0;
    #1;
    chk("arst_cnt", 32'(count), 0);
    chk("arst_valid", 32'(dev_valid), 0);
    chk("arst_data", dev_data, 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_full", 32'(full), 0);
    tick();
    clear = 1'b1;
    wr_en = 1'b1; wr_data = 32'h99; tick(); wr_en = 1'b0;
    chk("post_rst_cnt", 32'(count), 1);
    chk("post_rst_data", dev_data, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
